// File: rtl/io_ctl_gen_if.sv
// io_ctl_gen_if: CPU data-bus handshake between a bus master and the I/O
// controller.
//   ADDR : bus address; bit 31 selects I/O, [7:0] is the register offset
//   DIN  : write data, only [7:0] is used
//   WE   : write request
//   RREQ : read request
//   DO   : read data, {24'b0, byte}
//   RDY  : one-cycle access-complete pulse
interface io_ctl_gen_if;
  logic [31:0] ADDR;
  logic [31:0] DIN;
  logic        WE;
  logic        RREQ;
  logic [31:0] DO;
  logic        RDY;

  modport master (output ADDR, DIN, WE, RREQ, input DO, RDY);
  modport slave  (input ADDR, DIN, WE, RREQ, output DO, RDY);
endinterface

// File: rtl/io_ctl_gen.sv
// io_ctl_gen: parametrised memory-mapped I/O controller. Serves byte-wide
// register accesses on the CPU bus and drives switches, LEDs, a tri-state
// GPIO bank with rising-edge interrupts, and a multiplexed 7-segment display.
// Ports:
//   CLK, RST_N : clock and asynchronous active-low reset
//   bus        : slave side of the CPU bus handshake (io_ctl_gen_if)
//   SW         : board switches (synchronised internally)
//   GPIO       : tri-state pins, pin i driven when MODE[i]=1
//   LED        : LED drive
//   SSGD       : segments {dp,G,F,E,D,C,B,A}, active-high
//   SSGS       : one-hot digit select, active-high
//   IRQ        : level interrupt request
module io_ctl_gen #(
  parameter int GPIO_WIDTH  = 16,
  parameter int SSG_DIGITS  = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  io_ctl_gen_if.slave           bus,
  input  logic [7:0]            SW,
  inout  wire  [GPIO_WIDTH-1:0] GPIO,
  output logic [7:0]            LED,
  output logic [7:0]            SSGD,
  output logic [SSG_DIGITS-1:0] SSGS,
  output logic                  IRQ
);

  localparam int GPIO_BYTES = GPIO_WIDTH / 8;
  localparam int DIV_W      = $clog2(REFRESH_DIV);
  localparam int IDX_W      = (SSG_DIGITS > 1) ? $clog2(SSG_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic [7:0]              off;
  logic [7:0]              wdata;
  logic                    is_wr;
  logic [7:0]              led;
  logic [SSG_DIGITS-1:0]   ssg_en;
  logic                    irq_gen;
  logic [GPIO_WIDTH-1:0]   mode;
  logic [GPIO_WIDTH-1:0]   gpio_out;
  logic [GPIO_WIDTH-1:0]   irq_en;
  logic [GPIO_WIDTH-1:0]   irq_stat;
  logic [7:0]              ssg_data [SSG_DIGITS];

  logic [7:0]              sw_s1, sw_sync;
  logic [GPIO_WIDTH-1:0]   gpio_s1, gpio_sync, gpio_prev;

  logic [GPIO_WIDTH-1:0]   stat_set, stat_clr;
  logic [7:0]              rd_byte;
  logic [7:0]              ssg_en_rd;

  logic [DIV_W-1:0]        div;
  logic [IDX_W-1:0]        idx;

  logic                    unused_bits;
  assign unused_bits = ^{bus.ADDR[30:8], bus.DIN[31:8]};

  assign LED = led;

  // Each pin is driven only while its MODE bit selects output.
  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    assign GPIO[i] = mode[i] ? gpio_out[i] : 1'bz;
  end

  // Two-flop synchronisers, plus a third GPIO stage for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_s1     <= '0;
      sw_sync   <= '0;
      gpio_s1   <= '0;
      gpio_sync <= '0;
      gpio_prev <= '0;
    end else begin
      sw_s1     <= SW;
      sw_sync   <= sw_s1;
      gpio_s1   <= GPIO;
      gpio_sync <= gpio_s1;
      gpio_prev <= gpio_sync;
    end
  end

  // Rising edges on enabled input pins set status; W1C writes clear it.
  always_comb begin
    stat_set = gpio_sync & ~gpio_prev & irq_en & ~mode;
    stat_clr = '0;
    if (state == ACCESS && is_wr) begin
      for (int n = 0; n < GPIO_BYTES; n++) begin
        if (off == 8'(8'h20 + n)) stat_clr[8*n +: 8] = wdata;
      end
    end
  end

  // Read mux; anything not decoded returns 0xFF.
  always_comb begin
    ssg_en_rd                 = '0;
    ssg_en_rd[SSG_DIGITS-1:0] = ssg_en;
    rd_byte                   = 8'hFF;
    case (off)
      8'h00:   rd_byte = sw_sync;
      8'h01:   rd_byte = led;
      8'h02:   rd_byte = ssg_en_rd;
      8'h03:   rd_byte = {6'b0, |irq_stat, irq_gen};
      default: rd_byte = 8'hFF;
    endcase
    for (int n = 0; n < GPIO_BYTES; n++) begin
      if (off == 8'(8'h10 + n)) rd_byte = mode[8*n +: 8];
      if (off == 8'(8'h14 + n)) rd_byte = gpio_out[8*n +: 8];
      if (off == 8'(8'h18 + n)) rd_byte = gpio_sync[8*n +: 8];
      if (off == 8'(8'h1C + n)) rd_byte = irq_en[8*n +: 8];
      if (off == 8'(8'h20 + n)) rd_byte = irq_stat[8*n +: 8];
    end
    for (int d = 0; d < SSG_DIGITS; d++) begin
      if (off == 8'(8'h28 + d)) rd_byte = ssg_data[d];
    end
  end

  // Bus FSM and register file. Status set is OR-ed in after the clear so a
  // coincident edge wins over a W1C write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      off      <= '0;
      wdata    <= '0;
      is_wr    <= 1'b0;
      bus.DO   <= '0;
      bus.RDY  <= 1'b0;
      led      <= 8'hFF;
      ssg_en   <= '0;
      irq_gen  <= 1'b0;
      mode     <= '0;
      gpio_out <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      IRQ      <= 1'b0;
      for (int d = 0; d < SSG_DIGITS; d++) ssg_data[d] <= '0;
    end else begin
      bus.RDY  <= 1'b0;
      irq_stat <= (irq_stat & ~stat_clr) | stat_set;
      IRQ      <= irq_gen & (|irq_stat);
      case (state)
        IDLE: begin
          if (bus.ADDR[31] && (bus.WE || bus.RREQ)) begin
            off   <= bus.ADDR[7:0];
            wdata <= bus.DIN[7:0];
            is_wr <= bus.WE;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (is_wr) begin
            case (off)
              8'h01:   led     <= wdata;
              8'h02:   ssg_en  <= wdata[SSG_DIGITS-1:0];
              8'h03:   irq_gen <= wdata[0];
              default: ;
            endcase
            for (int n = 0; n < GPIO_BYTES; n++) begin
              if (off == 8'(8'h10 + n)) mode[8*n +: 8]     <= wdata;
              if (off == 8'(8'h14 + n)) gpio_out[8*n +: 8] <= wdata;
              if (off == 8'(8'h1C + n)) irq_en[8*n +: 8]   <= wdata;
            end
            for (int d = 0; d < SSG_DIGITS; d++) begin
              if (off == 8'(8'h28 + d)) ssg_data[d] <= wdata;
            end
          end else begin
            bus.DO <= {24'b0, rd_byte};
          end
          state <= RESP;
        end
        RESP: begin
          bus.RDY <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display scan: dwell REFRESH_DIV cycles per digit; parked at 0 when all
  // digits are disabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div <= '0;
      idx <= '0;
    end else if (ssg_en == '0) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_W'(REFRESH_DIV - 1)) begin
      div <= '0;
      idx <= (idx == IDX_W'(SSG_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    SSGS = '0;
    SSGD = '0;
    for (int d = 0; d < SSG_DIGITS; d++) begin
      if (idx == IDX_W'(d) && ssg_en[d]) begin
        SSGS[d] = 1'b1;
        SSGD    = ssg_data[d];
      end
    end
  end

endmodule

// File: tb/tb_io_ctl_gen.sv
// tb_io_ctl_gen: directed self-checking bench for io_ctl_gen, built with
// 16 GPIO pins, 3 display digits and a 4-cycle digit dwell.
module tb_io_ctl_gen;
  localparam int GW = 16;
  localparam int SD = 3;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    sw;
  wire  [GW-1:0] gpio_pins;
  logic [GW-1:0] tb_en;
  logic [GW-1:0] tb_val;
  logic [7:0]    led;
  logic [7:0]    ssgd;
  logic [SD-1:0] ssgs;
  logic          irq;

  int tests_run = 0;
  int tests_failed = 0;

  io_ctl_gen_if bus ();

  io_ctl_gen #(.GPIO_WIDTH(GW), .SSG_DIGITS(SD), .REFRESH_DIV(RD)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus),
    .SW   (sw),
    .GPIO (gpio_pins),
    .LED  (led),
    .SSGD (ssgd),
    .SSGS (ssgs),
    .IRQ  (irq)
  );

  always #5 clk = ~clk;

  // External pin drivers, released to Z unless enabled.
  for (genvar i = 0; i < GW; i++) begin : g_drv
    assign gpio_pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One bus access; returns the read byte and the number of edges to RDY.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] off,
                               input logic [7:0] data, output logic [31:0] rdata,
                               output int lat);
    @(negedge clk);
    bus.ADDR = {1'b1, 23'b0, off};
    bus.DIN  = {24'h0, data};
    bus.WE   = wr;
    bus.RREQ = rd;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.RDY && lat < 20);
    bus.WE   = 1'b0;
    bus.RREQ = 1'b0;
    if (!bus.RDY) checkOutput("rdy_timeout", 32'd0, 32'd1);
    rdata = bus.DO;
  endtask

  task automatic writeReg(input logic [7:0] off, input logic [7:0] data);
    logic [31:0] rdata;
    int lat;
    applyStimulus(1'b1, 1'b0, off, data, rdata, lat);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] off, input logic [7:0] exp);
    logic [31:0] rdata;
    int lat;
    applyStimulus(1'b0, 1'b1, off, 8'h00, rdata, lat);
    checkOutput(tag, rdata, {24'h0, exp});
  endtask

  initial begin
    logic [31:0] rdata;
    int          lat;
    int          pulses;
    int          digit;
    logic [2:0]  exp_s;
    logic [7:0]  exp_d;

    bus.ADDR = '0;
    bus.DIN  = '0;
    bus.WE   = 1'b0;
    bus.RREQ = 1'b0;
    sw       = 8'h3C;
    tb_en    = '0;
    tb_val   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_do", bus.DO, 32'h0);
    checkOutput("rst_rdy", {31'b0, bus.RDY}, 32'h0);
    checkOutput("rst_led", {24'b0, led}, 32'hFF);
    checkOutput("rst_ssgd", {24'b0, ssgd}, 32'h0);
    checkOutput("rst_ssgs", {29'b0, ssgs}, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset register values and access timing
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h00, rdata, lat);
    checkOutput("rd_led_rst", rdata, 32'hFF);
    checkOutput("rdy_latency", lat, 32'd3);
    @(posedge clk);
    #1;
    checkOutput("rdy_once", {31'b0, bus.RDY}, 32'h0);
    readCheck("rd_mode_rst", 8'h10, 8'h00);
    readCheck("rd_ssg0_rst", 8'h28, 8'h00);
    readCheck("rd_sw", 8'h00, 8'h3C);

    // GPIO drive and readback
    writeReg(8'h10, 8'h0F);
    writeReg(8'h14, 8'hA5);
    checkOutput("gpio_lo", {28'b0, gpio_pins[3:0]}, 32'h5);
    tb_en  = 16'hFFF0;
    tb_val = 16'hABC0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("gpio_hi_z", {20'b0, gpio_pins[15:4]}, 32'hABC);
    readCheck("rd_gpio_out", 8'h14, 8'hA5);
    readCheck("rd_gpio_in0", 8'h18, 8'hC5);
    readCheck("rd_gpio_in1", 8'h19, 8'hAB);
    readCheck("rd_unmapped", 8'h30, 8'hFF);
    readCheck("rd_mode_n2", 8'h12, 8'hFF);
    readCheck("rd_ssg_d3", 8'h2B, 8'hFF);
    writeReg(8'h00, 8'h11);
    readCheck("sw_ro", 8'h00, 8'h3C);

    // Interrupt set, pending, W1C
    writeReg(8'h10, 8'h0E);
    tb_en[0]  = 1'b1;
    tb_val[0] = 1'b0;
    writeReg(8'h1C, 8'h03);
    writeReg(8'h03, 8'h01);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("irq_idle", {31'b0, irq}, 32'h0);
    readCheck("stat_idle", 8'h20, 8'h00);
    @(negedge clk);
    tb_val[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("irq_set", {31'b0, irq}, 32'h1);
    readCheck("stat_set", 8'h20, 8'h01);
    readCheck("irq_ctrl_pend", 8'h03, 8'h03);
    writeReg(8'h20, 8'h01);
    checkOutput("irq_clr", {31'b0, irq}, 32'h0);
    readCheck("stat_clr", 8'h20, 8'h00);
    readCheck("irq_ctrl_nopend", 8'h03, 8'h01);

    // Clear landing on the same edge as a new set: set wins
    @(negedge clk);
    tb_val[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tb_val[0] = 1'b1;
    writeReg(8'h20, 8'h01);
    readCheck("stat_set_wins", 8'h20, 8'h01);
    writeReg(8'h20, 8'h01);
    readCheck("stat_clr2", 8'h20, 8'h00);

    // Edges that must not set status: output pin, and IRQ_EN=0 pin
    writeReg(8'h14, 8'hA7);
    checkOutput("gpio_pin1_out", {31'b0, gpio_pins[1]}, 32'h1);
    repeat (5) @(posedge clk);
    readCheck("stat_mode_out", 8'h20, 8'h00);
    @(negedge clk);
    tb_val[4] = 1'b1;
    repeat (5) @(posedge clk);
    readCheck("stat_en_off", 8'h20, 8'h00);
    readCheck("rd_gpio_in0b", 8'h18, 8'hD7);

    // WE and RREQ together performs the write
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h5A, rdata, lat);
    checkOutput("we_prio_led", {24'b0, led}, 32'h5A);
    readCheck("we_prio_rd", 8'h01, 8'h5A);

    // Held request produces back-to-back accesses, one RDY every 3 cycles
    @(negedge clk);
    bus.ADDR = {1'b1, 23'b0, 8'h01};
    bus.RREQ = 1'b1;
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      if (bus.RDY) pulses++;
    end
    bus.RREQ = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.RDY) pulses++;
    end
    checkOutput("b2b_pulses", pulses, 32'd3);

    // Display scan: digits 0 and 2 enabled
    writeReg(8'h28, 8'h06);
    writeReg(8'h29, 8'h5B);
    writeReg(8'h2A, 8'h4F);
    writeReg(8'h02, 8'h05);
    for (int t = 1; t <= 12; t++) begin
      digit = (t / 4) % 3;
      exp_s = (digit == 0) ? 3'b001 : (digit == 1) ? 3'b000 : 3'b100;
      exp_d = (digit == 0) ? 8'h06 : (digit == 1) ? 8'h00 : 8'h4F;
      checkOutput($sformatf("ssgs_t%0d", t), {29'b0, ssgs}, {29'b0, exp_s});
      checkOutput($sformatf("ssgd_t%0d", t), {24'b0, ssgd}, {24'b0, exp_d});
      @(posedge clk);
      #1;
    end
    readCheck("rd_ssg_en", 8'h02, 8'h05);
    writeReg(8'h02, 8'h00);
    checkOutput("ssgs_off", {29'b0, ssgs}, 32'h0);
    checkOutput("ssgd_off", {24'b0, ssgd}, 32'h0);

    // Reset pulsed while the write sits in ACCESS
    @(negedge clk);
    bus.ADDR = {1'b1, 23'b0, 8'h01};
    bus.DIN  = 32'h77;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.RDY) pulses++;
    end
    checkOutput("abort_no_rdy", pulses, 32'd0);
    checkOutput("abort_led", {24'b0, led}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/io_ctl_gen.md
# io_ctl_gen

Parametrised memory-mapped I/O controller on the CPU data bus, the generalised successor of the fixed board I/O block. It serves byte-wide register accesses when ADDR[31] is set and drives switches, LEDs, a GPIO_WIDTH-bit tri-state GPIO bank, and an SSG_DIGITS-digit multiplexed 7-segment display. Over the fixed block it adds per-pin rising-edge GPIO interrupts with write-1-to-clear status, per-digit display enables, and input synchronisers.

## Interface
- GPIO_WIDTH, 16: GPIO pins; multiple of 8, range 8..32; GPIO_BYTES = GPIO_WIDTH/8.
- SSG_DIGITS, 6: display digits, range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit dwell; minimum 2.
- CLK  in  1: single clock; all logic on posedge CLK.
- RST_N  in  1: reset, asynchronous and active-low.
- ADDR  in  32: bus address; bit 31 selects I/O; [7:0] is the register offset.
- DIN  in  32: write data; only [7:0] is used.
- WE  in  1: write request.
- RREQ  in  1: read request.
- SW  in  8: board switches.
- GPIO  inout  GPIO_WIDTH: pin i is driven when MODE[i]=1, else Z.
- DO  out  32: read data, {24'b0, byte}.
- RDY  out  1: one-cycle access-complete pulse.
- LED  out  8: LED drive.
- SSGD  out  8: segments {dp,G,F,E,D,C,B,A}, active-high.
- SSGS  out  SSG_DIGITS: digit select, one-hot, active-high.
- IRQ  out  1: level interrupt request.

## Operation
- Register map (offset = ADDR[7:0]; n < GPIO_BYTES; d < SSG_DIGITS):
  - 0x00 SW: RO, 2-flop synchronised.
  - 0x01 LED: RW, reset 0xFF.
  - 0x02 SSG_EN: RW, bit d enables digit d, reset 0x00.
  - 0x03 IRQ_CTRL: bit0 global enable (RW); bit1 pending (RO, = |IRQ_STAT); other bits read 0. Reset 0x00.
  - 0x10+n MODE: RW, 1 = output, reset 0x00.
  - 0x14+n GPIO_OUT: RW, reset 0x00.
  - 0x18+n GPIO_IN: RO, synchronised pins.
  - 0x1C+n IRQ_EN: RW, reset 0x00.
  - 0x20+n IRQ_STAT: read; writing 1 clears that bit. Reset 0x00.
  - 0x28+d SSG_DATA: RW, reset 0x00.
- Unmapped offsets, including n ≥ GPIO_BYTES and d ≥ SSG_DIGITS: reads return 0xFF; writes are ignored. Writes to RO registers are ignored.
- Bus FSM:
  - IDLE: if ADDR[31] & (WE|RREQ), latch offset, data and direction, then go to ACCESS. WE has priority over RREQ.
  - ACCESS: perform the write, or load DO with the read byte; go to RESP.
  - RESP: RDY=1 for this cycle only; go to IDLE.
  - A request still held in IDLE after RESP starts a new access. The master must drop WE/RREQ on seeing RDY.
- GPIO inputs pass through 2 flops into gpio_sync, plus one more flop into gpio_prev.
- Rising edge on pin i: gpio_sync[i] & ~gpio_prev[i] & IRQ_EN[i] & ~MODE[i] sets IRQ_STAT[i].
- If a set and a W1C clear hit the same bit in the same cycle, set wins.
- IRQ = IRQ_CTRL[0] & |IRQ_STAT, registered.
- Display scan:
  - Divider counts 0..REFRESH_DIV-1. At terminal count, digit index advances and wraps SSG_DIGITS-1 -> 0.
  - SSGS = one-hot(index) if SSG_EN[index], else 0.
  - SSGD = SSG_DATA[index] if SSG_EN[index], else 0.
  - When SSG_EN == 0: divider and index are held at 0, and SSGS = 0, SSGD = 0.

## Timing
- Reset values: DO=0, RDY=0, LED=0xFF, SSGD=0, SSGS=0, IRQ=0, GPIO all Z, FSM in IDLE, divider and index 0.
- Access latency: request sampled at edge k; register updates at edge k+1; RDY=1 and DO valid after edge k+2, for one cycle. DO then holds until the next read.
- Write-to-effect: LED, GPIO pin drive, MODE and SSG outputs change after edge k+1 (registered outputs).
- Pin-to-IRQ_STAT: 3 edges from pin change. IRQ asserts one edge after the status bit sets.
- Reset assertion mid-access aborts the access: no register update and no RDY pulse.
- Digit dwell is exactly REFRESH_DIV cycles. Full frame is REFRESH_DIV*SSG_DIGITS cycles.

## Test plan
- Reset, then read 0x01, 0x10 and 0x28 -> DO = 0xFF, 0x00, 0x00; RDY pulses exactly once per access, 2 cycles after the request edge; GPIO all Z.
- Write 0x10=0x0F, then 0x14=0xA5 -> GPIO[3:0]=0x5 driven, GPIO[15:4]=Z. Read 0x14 -> 0xA5. Read 0x30 -> 0xFF.
- Write 0x1C=0x01, 0x03=0x01, then drive GPIO[0] 0->1 -> IRQ_STAT bit0 = 1 and IRQ = 1. Write 0x20=0x01 -> IRQ = 0. A clear coinciding with a new edge leaves the bit set.
- Edge on a pin with MODE=1, or with IRQ_EN=0 -> no status bit set.
- REFRESH_DIV=4, SSG_DIGITS=3, SSG_EN=0x05, SSG_DATA = {0x06, 0x5B, 0x4F} -> SSGS cycles 001, 000, 100 at 4 cycles each, with SSGD = 0x06, 0x00, 0x4F. Write SSG_EN=0 -> SSGS = 0, SSGD = 0.
- WE and RREQ asserted together -> write performed; a held request produces back-to-back accesses; RST_N pulsed in ACCESS -> no RDY and the register is unchanged.
